cpu_decode: RTL and testbench

//  Decode/issue stage feeding CPU_Execute. Accepts one fetched instruction, reads rs1/rs2

---
 rtl/cpu_decode_if.sv | 40 ++++
 rtl/cpu_decode.sv | 208 ++++++++++++++++++++
 tb/tb_cpu_decode.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_decode_if.sv
// Fetch, register-file and execute signals around the decode/issue stage.
// slave: the decode stage itself; master: the surrounding fetch/RF/execute environment.
interface cpu_decode_if;
    logic        i_fetch_valid;
    logic [31:0] i_fetch_pc;
    logic [31:0] i_fetch_instruction;
    logic        o_fetch_ready;
    logic [4:0]  o_rs1_idx;
    logic [4:0]  o_rs2_idx;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic        o_execute;
    logic [31:0] o_pc;
    logic [31:0] o_instruction;
    logic [31:0] o_rs1;
    logic [31:0] o_rs2;
    logic [4:0]  o_inst_rd;
    logic [31:0] o_imm;
    logic        o_branch;
    logic        i_execute_ready;
    logic [4:0]  i_execute_rd;
    logic [31:0] i_execute_value;
    logic        o_illegal;

    modport slave (
        input  i_fetch_valid, i_fetch_pc, i_fetch_instruction,
        input  i_rs1_data, i_rs2_data,
        input  i_execute_ready, i_execute_rd, i_execute_value,
        output o_fetch_ready, o_rs1_idx, o_rs2_idx, o_execute, o_pc, o_instruction,
        output o_rs1, o_rs2, o_inst_rd, o_imm, o_branch, o_illegal
    );

    modport master (
        output i_fetch_valid, i_fetch_pc, i_fetch_instruction,
        output i_rs1_data, i_rs2_data,
        output i_execute_ready, i_execute_rd, i_execute_value,
        input  o_fetch_ready, o_rs1_idx, o_rs2_idx, o_execute, o_pc, o_instruction,
        input  o_rs1, o_rs2, o_inst_rd, o_imm, o_branch, o_illegal
    );
endinterface

// File: rtl/cpu_decode.sv
// Decode/issue stage: accept one instruction, read operands, issue to execute, wait for done.
// Optional macro DECODE_FORWARD_EN adds a one-entry result forward and skips the WB cycle.
module cpu_decode #(
    parameter int unsigned RF_LATENCY = 1
) (
    input  logic           i_clock,
    input  logic           i_reset,
    cpu_decode_if.slave    io_dec
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned RIDX  = 5;
    localparam int unsigned CNT_W = 2;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_ISSUE, S_WAIT, S_WB} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_fetch_ready, r_execute, r_illegal, r_branch;
    logic [XLEN-1:0]   r_pc, r_instr, r_rs1, r_rs2, r_imm;
    logic [RIDX-1:0]   r_rs1_idx, r_rs2_idx, r_rd;

    logic [XLEN-1:0]   w_instr, w_imm, w_rs1_val, w_rs2_val;
    logic [RIDX-1:0]   w_rd;
    logic              w_legal, w_branch, w_accept;
    logic              w_execute_nxt, w_illegal_nxt, w_load_fetch, w_capture;

    assign w_instr  = io_dec.i_fetch_instruction;
    assign w_accept = r_fetch_ready & io_dec.i_fetch_valid;

    // Opcode classification, destination and immediate of the offered instruction
    always_comb begin
        w_legal  = 1'b1;
        w_branch = 1'b0;
        w_rd     = w_instr[11:7];
        w_imm    = '0;
        case (w_instr[6:0])
            OP_LUI, OP_AUIPC: w_imm = {w_instr[31:12], 12'b0};
            OP_JAL: begin
                w_imm    = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                            w_instr[30:21], 1'b0};
                w_branch = 1'b1;
            end
            OP_JALR: begin
                w_imm    = {{20{w_instr[31]}}, w_instr[31:20]};
                w_branch = 1'b1;
            end
            OP_BRANCH: begin
                w_imm    = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                            w_instr[11:8], 1'b0};
                w_branch = 1'b1;
                w_rd     = '0;
            end
            OP_LOAD, OP_IMM: w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
            OP_STORE: begin
                w_imm = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
                w_rd  = '0;
            end
            OP_OP: w_imm = '0;
            default: begin
                w_legal = 1'b0;
                w_rd    = '0;
            end
        endcase
    end

    // State register
    always_ff @(posedge i_clock) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_legal) w_state_nxt = S_READ;
            S_READ:  if (r_cnt == '0) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
`ifdef DECODE_FORWARD_EN
            S_WAIT:  if (io_dec.i_execute_ready) w_state_nxt = S_IDLE;
`else
            S_WAIT:  if (io_dec.i_execute_ready) w_state_nxt = S_WB;
`endif
            S_WB:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output/datapath control derived from the current state
    always_comb begin
        w_execute_nxt = 1'b0;
        w_illegal_nxt = 1'b0;
        w_load_fetch  = 1'b0;
        w_capture     = 1'b0;
        w_cnt_nxt     = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_load_fetch  = w_legal;
                    w_illegal_nxt = ~w_legal;
                    if (w_legal) w_cnt_nxt = CNT_W'(RF_LATENCY);
                end
            end
            S_READ: begin
                if (r_cnt == '0) begin
                    w_capture     = 1'b1;
                    w_execute_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

`ifdef DECODE_FORWARD_EN
    logic [RIDX-1:0] r_fwd_rd;
    logic [XLEN-1:0] r_fwd_val;

    // Most recent execute result, captured only while waiting on execute
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_fwd_rd  <= '0;
            r_fwd_val <= '0;
        end else if (r_state == S_WAIT && io_dec.i_execute_ready) begin
            r_fwd_rd  <= io_dec.i_execute_rd;
            r_fwd_val <= io_dec.i_execute_value;
        end
    end

    always_comb begin
        w_rs1_val = io_dec.i_rs1_data;
        w_rs2_val = io_dec.i_rs2_data;
        if (r_rs1_idx == r_fwd_rd) w_rs1_val = r_fwd_val;
        if (r_rs2_idx == r_fwd_rd) w_rs2_val = r_fwd_val;
        if (r_rs1_idx == '0) w_rs1_val = '0;
        if (r_rs2_idx == '0) w_rs2_val = '0;
    end
`else
    logic w_unused;
    assign w_unused = ^{io_dec.i_execute_rd, io_dec.i_execute_value};

    always_comb begin
        w_rs1_val = (r_rs1_idx == '0) ? '0 : io_dec.i_rs1_data;
        w_rs2_val = (r_rs2_idx == '0) ? '0 : io_dec.i_rs2_data;
    end
`endif

    // Registered outputs and instruction context
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_fetch_ready <= 1'b0;
            r_execute     <= 1'b0;
            r_illegal     <= 1'b0;
            r_cnt         <= '0;
            r_pc          <= '0;
            r_instr       <= '0;
            r_rs1_idx     <= '0;
            r_rs2_idx     <= '0;
            r_rd          <= '0;
            r_imm         <= '0;
            r_branch      <= 1'b0;
            r_rs1         <= '0;
            r_rs2         <= '0;
        end else begin
            r_fetch_ready <= (w_state_nxt == S_IDLE);
            r_execute     <= w_execute_nxt;
            r_illegal     <= w_illegal_nxt;
            r_cnt         <= w_cnt_nxt;
            if (w_load_fetch) begin
                r_pc      <= io_dec.i_fetch_pc;
                r_instr   <= w_instr;
                r_rs1_idx <= w_instr[19:15];
                r_rs2_idx <= w_instr[24:20];
                r_rd      <= w_rd;
                r_imm     <= w_imm;
                r_branch  <= w_branch;
            end
            if (w_capture) begin
                r_rs1 <= w_rs1_val;
                r_rs2 <= w_rs2_val;
            end
        end
    end

    assign io_dec.o_fetch_ready = r_fetch_ready;
    assign io_dec.o_rs1_idx     = r_rs1_idx;
    assign io_dec.o_rs2_idx     = r_rs2_idx;
    assign io_dec.o_execute     = r_execute;
    assign io_dec.o_pc          = r_pc;
    assign io_dec.o_instruction = r_instr;
    assign io_dec.o_rs1         = r_rs1;
    assign io_dec.o_rs2         = r_rs2;
    assign io_dec.o_inst_rd     = r_rd;
    assign io_dec.o_imm         = r_imm;
    assign io_dec.o_branch      = r_branch;
    assign io_dec.o_illegal     = r_illegal;
endmodule

// File: tb/tb_cpu_decode.sv
// Directed bench for cpu_decode: vector table on an RF_LATENCY=1 instance,
// plus latency and reset-in-WAIT sequences on an RF_LATENCY=3 instance.
module tb_cpu_decode;
`ifdef DECODE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] exp_rs1;
        logic [31:0] exp_rs2;
        logic [31:0] exp_imm;
        logic [4:0]  exp_rd;
        logic        exp_br;
        logic        exp_ill;
        logic [4:0]  ex_rd;
        logic [31:0] ex_val;
    } vec_t;

    logic clk;
    logic rst_n;
    logic rst3_n;
    int   n_checks;
    int   n_errors;
    logic [31:0] rf [32];
    logic [31:0] p3a [2];
    logic [31:0] p3b [2];
    vec_t vecs [10];

    cpu_decode_if if1 ();
    cpu_decode_if if3 ();

    cpu_decode #(.RF_LATENCY(1)) u_dut  (.i_clock(clk), .i_reset(rst_n),  .io_dec(if1));
    cpu_decode #(.RF_LATENCY(3)) u_dut3 (.i_clock(clk), .i_reset(rst3_n), .io_dec(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file models with one and three cycles of read latency
    always @(posedge clk) begin
        if1.i_rs1_data <= rf[if1.o_rs1_idx];
        if1.i_rs2_data <= rf[if1.o_rs2_idx];
        p3a[0] <= rf[if3.o_rs1_idx];
        p3b[0] <= rf[if3.o_rs2_idx];
        p3a[1] <= p3a[0];
        p3b[1] <= p3b[0];
        if3.i_rs1_data <= p3a[1];
        if3.i_rs2_data <= p3b[1];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        int   n;
        logic seen;
        n = 0;
        while (!if1.o_fetch_ready && n < 20) begin
            tick();
            n++;
        end
        check($sformatf("v%0d_fetch_ready", i), 32'(if1.o_fetch_ready), 32'd1);
        if1.i_fetch_valid       = 1'b1;
        if1.i_fetch_pc          = vecs[i].pc;
        if1.i_fetch_instruction = vecs[i].instr;
        tick();
        if1.i_fetch_valid = 1'b0;
        if (vecs[i].exp_ill) begin
            check($sformatf("v%0d_illegal", i), 32'(if1.o_illegal), 32'd1);
            tick();
            check($sformatf("v%0d_illegal_pulse", i), 32'(if1.o_illegal), 32'd0);
            seen = 1'b0;
            for (int k = 0; k < 6; k++) begin
                seen |= if1.o_execute;
                tick();
            end
            check($sformatf("v%0d_no_execute", i), 32'(seen), 32'd0);
            check($sformatf("v%0d_ready_after_ill", i), 32'(if1.o_fetch_ready), 32'd1);
        end else begin
            check($sformatf("v%0d_no_illegal", i), 32'(if1.o_illegal), 32'd0);
            n = 0;
            while (!if1.o_execute && n < 20) begin
                tick();
                n++;
            end
            check($sformatf("v%0d_issue_latency", i), 32'(n), 32'd2);
            check($sformatf("v%0d_pc", i), if1.o_pc, vecs[i].pc);
            check($sformatf("v%0d_instruction", i), if1.o_instruction, vecs[i].instr);
            check($sformatf("v%0d_rs1", i), if1.o_rs1, vecs[i].exp_rs1);
            check($sformatf("v%0d_rs2", i), if1.o_rs2, vecs[i].exp_rs2);
            check($sformatf("v%0d_imm", i), if1.o_imm, vecs[i].exp_imm);
            check($sformatf("v%0d_rd", i), 32'(if1.o_inst_rd), 32'(vecs[i].exp_rd));
            check($sformatf("v%0d_branch", i), 32'(if1.o_branch), 32'(vecs[i].exp_br));
            tick();
            check($sformatf("v%0d_execute_drop", i), 32'(if1.o_execute), 32'd0);
            check($sformatf("v%0d_wait_not_ready", i), 32'(if1.o_fetch_ready), 32'd0);
            tick();
            tick();
            check($sformatf("v%0d_wait_no_reissue", i), 32'(if1.o_execute), 32'd0);
            check($sformatf("v%0d_wait_rs1_hold", i), if1.o_rs1, vecs[i].exp_rs1);
            check($sformatf("v%0d_wait_imm_hold", i), if1.o_imm, vecs[i].exp_imm);
            if1.i_execute_ready = 1'b1;
            if1.i_execute_rd    = vecs[i].ex_rd;
            if1.i_execute_value = vecs[i].ex_val;
            tick();
            if1.i_execute_ready = 1'b0;
            if1.i_execute_rd    = '0;
            if1.i_execute_value = '0;
            check($sformatf("v%0d_ready_after_done", i), 32'(if1.o_fetch_ready), 32'(FWD));
            check($sformatf("v%0d_done_no_execute", i), 32'(if1.o_execute), 32'd0);
        end
    endtask

    initial begin
        int   n;
        logic seen;
        n_checks = 0;
        n_errors = 0;
        for (int r = 0; r < 32; r++) rf[r] = 32'h1000_0000 + 32'(r);
        rf[0] = 32'hDEAD_BEEF;
        rf[1] = 32'h0000_0010;
        rf[3] = 32'h0000_0011;

        //           instr          pc            rs1           rs2           imm           rd  br ill exrd exval
        vecs[0] = '{32'hFFF08293, 32'h0000_0100, 32'h0000_0010, 32'h1000_001F, 32'hFFFF_FFFF, 5'd5, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[1] = '{32'h00208463, 32'h0000_0104, 32'h0000_0010, 32'h1000_0002, 32'h0000_0008, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0};
        vecs[2] = '{32'h00100393, 32'h0000_0108, 32'h0000_0000, 32'h0000_0010, 32'h0000_0001, 5'd7, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[3] = '{32'hFFFFFFFF, 32'h0000_010C, 32'h0,         32'h0,         32'h0,         5'd0, 1'b0, 1'b1, 5'd0, 32'h0};
        vecs[4] = '{32'h123454B7, 32'h0000_0110, 32'h1000_0008, 32'h0000_0011, 32'h1234_5000, 5'd9, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[5] = '{32'h008000EF, 32'h0000_0114, 32'h0000_0000, 32'h1000_0008, 32'h0000_0008, 5'd1, 1'b1, 1'b0, 5'd0, 32'h0};
        vecs[6] = '{32'hFE20AE23, 32'h0000_0118, 32'h0000_0010, 32'h1000_0002, 32'hFFFF_FFFC, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[7] = '{32'h000280E7, 32'h0000_011C, 32'h1000_0005, 32'h0000_0000, 32'h0000_0000, 5'd1, 1'b1, 1'b0, 5'd0, 32'h0};
        vecs[8] = '{32'h00500193, 32'h0000_0120, 32'h0000_0000, 32'h1000_0005, 32'h0000_0005, 5'd3, 1'b0, 1'b0, 5'd3, 32'h55};
        vecs[9] = '{32'h00318233, 32'h0000_0124, FWD ? 32'h55 : 32'h11, FWD ? 32'h55 : 32'h11,
                    32'h0, 5'd4, 1'b0, 1'b0, 5'd0, 32'h0};

        rst_n  = 1'b0;
        rst3_n = 1'b0;
        if1.i_fetch_valid = 1'b1;  if1.i_fetch_pc = 32'h40;  if1.i_fetch_instruction = 32'hFFF08293;
        if1.i_execute_ready = 1'b0; if1.i_execute_rd = '0; if1.i_execute_value = '0;
        if3.i_fetch_valid = 1'b1;  if3.i_fetch_pc = 32'h40;  if3.i_fetch_instruction = 32'hFFF08293;
        if3.i_execute_ready = 1'b0; if3.i_execute_rd = '0; if3.i_execute_value = '0;

        // Reset held with a valid fetch offered
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("rst%0d_fetch_ready", c), 32'(if1.o_fetch_ready), 32'd0);
            check($sformatf("rst%0d_execute", c), 32'(if1.o_execute), 32'd0);
        end
        check("rst_pc", if1.o_pc, 32'h0);
        check("rst_rs1", if1.o_rs1, 32'h0);
        check("rst_imm", if1.o_imm, 32'h0);
        check("rst_rd", 32'(if1.o_inst_rd), 32'h0);
        check("rst_idx", 32'({if1.o_rs1_idx, if1.o_rs2_idx}), 32'h0);
        check("rst_illegal", 32'(if1.o_illegal), 32'h0);
        if1.i_fetch_valid = 1'b0;
        if3.i_fetch_valid = 1'b0;
        rst_n  = 1'b1;
        rst3_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(i);

        // RF_LATENCY=3: issue latency, then reset while waiting on execute
        n = 0;
        while (!if3.o_fetch_ready && n < 20) begin
            tick();
            n++;
        end
        check("l3_fetch_ready", 32'(if3.o_fetch_ready), 32'd1);
        if3.i_fetch_valid       = 1'b1;
        if3.i_fetch_pc          = 32'h0000_0200;
        if3.i_fetch_instruction = 32'hFFF08293;
        tick();
        if3.i_fetch_valid = 1'b0;
        n = 0;
        while (!if3.o_execute && n < 20) begin
            tick();
            n++;
        end
        check("l3_issue_latency", 32'(n), 32'd4);
        check("l3_rs1", if3.o_rs1, 32'h0000_0010);
        check("l3_pc", if3.o_pc, 32'h0000_0200);
        tick();
        tick();
        check("l3_wait_no_reissue", 32'(if3.o_execute), 32'd0);
        rst3_n = 1'b0;
        tick();
        rst3_n = 1'b1;
        check("l3_rst_pc", if3.o_pc, 32'h0);
        check("l3_rst_ready", 32'(if3.o_fetch_ready), 32'd0);
        if3.i_execute_ready = 1'b1;
        tick();
        if3.i_execute_ready = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            seen |= if3.o_execute;
            tick();
        end
        check("l3_no_execute_after_rst", 32'(seen), 32'd0);
        check("l3_idle_after_rst", 32'(if3.o_fetch_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
